// File: rtl/memory_access_ctrl.sv
// Burst sequencer driving a single-port synchronous RAM (1-cycle read latency)
// behind valid/ready command, write-data and read-data ports.
module memory_access_ctrl #(
  parameter int unsigned A = 8,
  parameter int unsigned D = 8,
  parameter int unsigned L = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [A-1:0] req_addr,
  input  logic [L-1:0] req_len,
  input  logic         wdata_valid,
  output logic         wdata_ready,
  input  logic [D-1:0] wdata,
  output logic         rdata_valid,
  input  logic         rdata_ready,
  output logic [D-1:0] rdata,
  output logic         done,
  output logic         mem_ce,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [D-1:0] mem_data,
  input  logic [D-1:0] mem_q
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD_ISS = 3'd2,
    S_RD_CAP = 3'd3,
    S_RD_OUT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t       state;
  logic [A-1:0] cur_addr;
  logic [L-1:0] beat_cnt;
  logic [D-1:0] rdata_q;

  // Sequencer state, burst pointer/counter and captured read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      beat_cnt <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cur_addr <= req_addr;
            beat_cnt <= req_len;
            state    <= req_we ? S_WR : S_RD_ISS;
          end
        end
        S_WR: begin
          if (wdata_valid) begin
            if (beat_cnt == '0) begin
              state <= S_DONE;
            end else begin
              cur_addr <= cur_addr + A'(1);
              beat_cnt <= beat_cnt - L'(1);
            end
          end
        end
        S_RD_ISS: state <= S_RD_CAP;
        S_RD_CAP: begin
          rdata_q <= mem_q;
          state   <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (rdata_ready) begin
            if (beat_cnt == '0) begin
              state <= S_DONE;
            end else begin
              cur_addr <= cur_addr + A'(1);
              beat_cnt <= beat_cnt - L'(1);
              state    <= S_RD_ISS;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register; write strobes
  // follow wdata_valid in the same cycle so a write beat costs one cycle.
  assign req_ready   = (state == S_IDLE);
  assign wdata_ready = (state == S_WR);
  assign rdata_valid = (state == S_RD_OUT);
  assign done        = (state == S_DONE);
  assign mem_we      = (state == S_WR) && wdata_valid;
  assign mem_ce      = mem_we || (state == S_RD_ISS);
  assign mem_addr    = cur_addr;
  assign mem_data    = wdata;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Self-checking bench for memory_access_ctrl: a RAM device model on the memory
// pins plus an expected-contents array updated from completed burst transactions.
module tb_memory_access_ctrl;

  localparam int unsigned A = 8;
  localparam int unsigned D = 8;
  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_we;
  logic [A-1:0] req_addr;
  logic [L-1:0] req_len;
  logic         wdata_valid, wdata_ready;
  logic [D-1:0] wdata;
  logic         rdata_valid, rdata_ready;
  logic [D-1:0] rdata;
  logic         done, mem_ce, mem_we;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_data;
  logic [D-1:0] mem_q;

  int n_chk  = 0;
  int n_pass = 0;

  logic [D-1:0] ram     [2**A];
  logic [D-1:0] exp_mem [2**A];
  logic [D-1:0] wbuf    [2**L];

  always #5 clk = ~clk;

  memory_access_ctrl #(.A(A), .D(D), .L(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .done(done),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_q(mem_q)
  );

  // Single-port synchronous RAM; address 0 is hardwired to zero.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= (mem_addr == '0) ? '0 : mem_data;
      else        mem_q <= (mem_addr == '0) ? '0 : ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string pfx);
    chk({pfx, "_req_ready"},   32'(req_ready),   32'd1);
    chk({pfx, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
    chk({pfx, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
    chk({pfx, "_done"},        32'(done),        32'd0);
    chk({pfx, "_mem_ce"},      32'(mem_ce),      32'd0);
    chk({pfx, "_mem_we"},      32'(mem_we),      32'd0);
    chk({pfx, "_mem_addr"},    32'(mem_addr),    32'd0);
    chk({pfx, "_mem_data"},    32'(mem_data),    32'd0);
    chk({pfx, "_rdata"},       32'(rdata),       32'd0);
  endtask

  task automatic scramble_req();
    req_we   = 1'($urandom);
    req_addr = A'($urandom);
    req_len  = L'($urandom);
  endtask

  task automatic wr_burst(input logic [A-1:0] addr, input logic [L-1:0] len, input int gap_pct);
    logic [A-1:0] a;
    int gaps;
    chk("wr_req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = len;
    tick();
    req_valid = 1'b0;
    scramble_req();
    chk("wr_req_ready_busy", 32'(req_ready), 32'd0);
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + A'(b);
      gaps = 0;
      while (gaps < 4 && int'($urandom_range(99)) < gap_pct) begin
        wdata_valid = 1'b0; wdata = D'($urandom);
        #1;
        chk("wr_gap_ce", 32'(mem_ce), 32'd0);
        chk("wr_gap_we", 32'(mem_we), 32'd0);
        chk("wr_gap_wdata_ready", 32'(wdata_ready), 32'd1);
        chk("wr_gap_addr", 32'(mem_addr), 32'(a));
        tick();
        gaps++;
      end
      wdata_valid = 1'b1; wdata = wbuf[b];
      #1;
      chk("wr_ce", 32'(mem_ce), 32'd1);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'(a));
      chk("wr_data", 32'(mem_data), 32'(wbuf[b]));
      tick();
      exp_mem[a] = (a == '0) ? '0 : wbuf[b];
    end
    wdata_valid = 1'b0; wdata = '0;
    #1;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_done_wdata_ready", 32'(wdata_ready), 32'd0);
    chk("wr_done_ce", 32'(mem_ce), 32'd0);
    chk("wr_done_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("wr_done_pulse_end", 32'(done), 32'd0);
    chk("wr_idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  // stall < 0 picks a random stall of 0..3 cycles per beat; abort_beat >= 0
  // pulls reset right after that beat's RAM read was issued.
  task automatic rd_burst(input logic [A-1:0] addr, input logic [L-1:0] len,
                          input int stall, input int abort_beat);
    logic [A-1:0] a;
    int n;
    chk("rd_req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len;
    tick();
    req_valid = 1'b0;
    scramble_req();
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + A'(b);
      rdata_ready = 1'($urandom);
      wdata_valid = 1'($urandom);
      #1;
      chk("rd_iss_ce", 32'(mem_ce), 32'd1);
      chk("rd_iss_we", 32'(mem_we), 32'd0);
      chk("rd_iss_addr", 32'(mem_addr), 32'(a));
      chk("rd_iss_valid", 32'(rdata_valid), 32'd0);
      tick();
      if (b == abort_beat) begin
        rst_n = 1'b0; wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        #1;
        check_reset_outs("abort");
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("abort_no_done", 32'(done), 32'd0);
          chk("abort_no_ce", 32'(mem_ce), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_no_done_rel", 32'(done), 32'd0);
        return;
      end
      chk("rd_cap_ce", 32'(mem_ce), 32'd0);
      chk("rd_cap_valid", 32'(rdata_valid), 32'd0);
      tick();
      n = (stall < 0) ? int'($urandom_range(3)) : stall;
      rdata_ready = (n == 0);
      #1;
      chk("rd_out_valid", 32'(rdata_valid), 32'd1);
      chk("rd_out_data", 32'(rdata), 32'(exp_mem[a]));
      for (int k = 0; k < n; k++) begin
        tick();
        chk("rd_stall_valid", 32'(rdata_valid), 32'd1);
        chk("rd_stall_data", 32'(rdata), 32'(exp_mem[a]));
        chk("rd_stall_ce", 32'(mem_ce), 32'd0);
        if (k == n - 1) rdata_ready = 1'b1;
      end
      tick();
    end
    rdata_ready = 1'b0; wdata_valid = 1'b0; wdata = '0;
    #1;
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_done_valid", 32'(rdata_valid), 32'd0);
    chk("rd_done_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("rd_done_pulse_end", 32'(done), 32'd0);
    chk("rd_idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [A-1:0] ra;
    logic [L-1:0] rl;
    for (int i = 0; i < 2**A; i++) begin
      ram[i] = '0;
      exp_mem[i] = '0;
    end
    mem_q = '0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    tick(); tick(); tick();
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick();
    check_reset_outs("post_reset");

    // Directed write then read-back at 0x10.
    for (int i = 0; i < 4; i++) wbuf[i] = D'(8'hA1 + i);
    wr_burst(8'h10, 4'd3, 0);
    rd_burst(8'h10, 4'd3, 0, -1);

    // Wrap across the top of memory into the zero-hardwired address.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    wr_burst(8'hFE, 4'd2, 0);
    rd_burst(8'hFE, 4'd2, 0, -1);

    // Consumer stall of five cycles on every beat.
    rd_burst(8'h11, 4'd1, 5, -1);

    // Producer gaps during a write burst.
    for (int i = 0; i < 6; i++) wbuf[i] = D'($urandom);
    wr_burst(8'h40, 4'd5, 60);
    rd_burst(8'h40, 4'd5, -1, -1);

    // Reset mid-way through a long read, then a normal transaction.
    for (int i = 0; i < 8; i++) wbuf[i] = D'(8'hC0 + i);
    wr_burst(8'h60, 4'd7, 0);
    rd_burst(8'h60, 4'd7, 0, 3);
    for (int i = 0; i < 2; i++) wbuf[i] = D'(8'h5A + i);
    wr_burst(8'h80, 4'd1, 0);
    rd_burst(8'h80, 4'd1, 0, -1);

    // Maximum-length burst.
    for (int i = 0; i < 2**L; i++) wbuf[i] = D'($urandom);
    wr_burst(8'hF8, 4'hF, 20);
    rd_burst(8'hF8, 4'hF, -1, -1);

    // Random mix of bursts against the expected-contents array.
    for (int t = 0; t < 40; t++) begin
      ra = A'($urandom);
      rl = L'($urandom_range(7));
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < 2**L; i++) wbuf[i] = D'($urandom);
        wr_burst(ra, rl, 30);
      end else begin
        rd_burst(ra, rl, -1, -1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
